// File: rtl/iq_select_arbiter.sv
// Oldest-first issue-queue select: occupancy + age matrix, one grant per execution port per cycle.
// Grants, occupancy and free count are all registered; granted and flushed entries free at the same edge.
module iq_select_arbiter #(
    parameter int IQ_ENT_NUM = 16,
    parameter int IQ_ENT_SEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid_1,
    input  logic [IQ_ENT_SEL-1:0] alloc_idx_1,
    input  logic                  alloc_port_1,
    input  logic                  alloc_valid_2,
    input  logic [IQ_ENT_SEL-1:0] alloc_idx_2,
    input  logic                  alloc_port_2,
    input  logic [IQ_ENT_NUM-1:0] request,
    input  logic                  port_ready_1,
    input  logic                  port_ready_2,
    input  logic [IQ_ENT_NUM-1:0] flush_mask,
    output logic                  grant_valid_1,
    output logic [IQ_ENT_SEL-1:0] grant_idx_1,
    output logic                  grant_valid_2,
    output logic [IQ_ENT_SEL-1:0] grant_idx_2,
    output logic [IQ_ENT_NUM-1:0] entry_valid,
    output logic [IQ_ENT_SEL:0]   free_count,
    output logic                  allocatable
);

    logic [IQ_ENT_NUM-1:0]                 entry_port;
    logic [IQ_ENT_NUM-1:0][IQ_ENT_NUM-1:0] age;

    logic [IQ_ENT_NUM-1:0]                 elig_1, elig_2, win_1, win_2;
    logic [IQ_ENT_SEL-1:0]                 win_idx_1, win_idx_2;
    logic [IQ_ENT_NUM-1:0]                 valid_post, valid_nxt, port_nxt;
    logic [IQ_ENT_NUM-1:0][IQ_ENT_NUM-1:0] age_nxt;
    logic [IQ_ENT_SEL:0]                   used_cnt, free_nxt;

    assign elig_1 = entry_valid & request & ~entry_port & ~flush_mask;
    assign elig_2 = entry_valid & request &  entry_port & ~flush_mask;

    // An entry wins if no other eligible entry on its port is older (age[j][i] set).
    always_comb begin
        win_1     = '0;
        win_2     = '0;
        win_idx_1 = '0;
        win_idx_2 = '0;
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            logic blk_1, blk_2;
            blk_1 = 1'b0;
            blk_2 = 1'b0;
            for (int j = 0; j < IQ_ENT_NUM; j++) begin
                if (elig_1[j] && age[j][i]) blk_1 = 1'b1;
                if (elig_2[j] && age[j][i]) blk_2 = 1'b1;
            end
            win_1[i] = elig_1[i] & ~blk_1 & port_ready_1;
            win_2[i] = elig_2[i] & ~blk_2 & port_ready_2;
            if (win_1[i]) win_idx_1 = IQ_ENT_SEL'(i);
            if (win_2[i]) win_idx_2 = IQ_ENT_SEL'(i);
        end
    end

    // Allocation is applied after grant/flush clearing so a new entry always survives.
    always_comb begin
        valid_post = entry_valid & ~flush_mask & ~win_1 & ~win_2;
        valid_nxt  = valid_post;
        port_nxt   = entry_port;
        age_nxt    = age;
        if (alloc_valid_1) begin
            valid_nxt[alloc_idx_1] = 1'b1;
            port_nxt[alloc_idx_1]  = alloc_port_1;
            for (int k = 0; k < IQ_ENT_NUM; k++) begin
                age_nxt[k][alloc_idx_1] = valid_post[k];
            end
            age_nxt[alloc_idx_1] = '0;
        end
        if (alloc_valid_2) begin
            valid_nxt[alloc_idx_2] = 1'b1;
            port_nxt[alloc_idx_2]  = alloc_port_2;
            for (int k = 0; k < IQ_ENT_NUM; k++) begin
                age_nxt[k][alloc_idx_2] = valid_post[k];
            end
            // Slot 1 is program-older than slot 2 in the same cycle.
            if (alloc_valid_1) age_nxt[alloc_idx_1][alloc_idx_2] = 1'b1;
            age_nxt[alloc_idx_2] = '0;
        end
    end

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < IQ_ENT_NUM; i++) begin
            used_cnt = used_cnt + (IQ_ENT_SEL+1)'(valid_nxt[i]);
        end
        free_nxt = (IQ_ENT_SEL+1)'(IQ_ENT_NUM) - used_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid   <= '0;
            entry_port    <= '0;
            age           <= '0;
            grant_valid_1 <= 1'b0;
            grant_idx_1   <= '0;
            grant_valid_2 <= 1'b0;
            grant_idx_2   <= '0;
            free_count    <= (IQ_ENT_SEL+1)'(IQ_ENT_NUM);
            allocatable   <= 1'b1;
        end else begin
            entry_valid   <= valid_nxt;
            entry_port    <= port_nxt;
            age           <= age_nxt;
            grant_valid_1 <= |win_1;
            grant_valid_2 <= |win_2;
            if (|win_1) grant_idx_1 <= win_idx_1;
            if (|win_2) grant_idx_2 <= win_idx_2;
            free_count    <= free_nxt;
            allocatable   <= (free_nxt >= (IQ_ENT_SEL+1)'(2));
        end
    end

endmodule

// File: tb/tb_iq_select_arbiter.sv
// Directed bench for iq_select_arbiter: age ordering, port back-pressure, flush, and fill/free boundaries.
module tb_iq_select_arbiter;

    localparam int N = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_valid_1, alloc_port_1, alloc_valid_2, alloc_port_2;
    logic [S-1:0] alloc_idx_1, alloc_idx_2;
    logic [N-1:0] request, flush_mask;
    logic         port_ready_1, port_ready_2;
    logic         grant_valid_1, grant_valid_2, allocatable;
    logic [S-1:0] grant_idx_1, grant_idx_2;
    logic [N-1:0] entry_valid;
    logic [S:0]   free_count;

    int tests  = 0;
    int failed = 0;

    iq_select_arbiter #(.IQ_ENT_NUM(N), .IQ_ENT_SEL(S)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid_1(alloc_valid_1), .alloc_idx_1(alloc_idx_1), .alloc_port_1(alloc_port_1),
        .alloc_valid_2(alloc_valid_2), .alloc_idx_2(alloc_idx_2), .alloc_port_2(alloc_port_2),
        .request(request), .port_ready_1(port_ready_1), .port_ready_2(port_ready_2),
        .flush_mask(flush_mask),
        .grant_valid_1(grant_valid_1), .grant_idx_1(grant_idx_1),
        .grant_valid_2(grant_valid_2), .grant_idx_2(grant_idx_2),
        .entry_valid(entry_valid), .free_count(free_count), .allocatable(allocatable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, then drop single-cycle controls.
    task automatic tick();
        assert (!(alloc_valid_1 && alloc_valid_2 && alloc_idx_1 == alloc_idx_2));
        assert (!(alloc_valid_1 && entry_valid[alloc_idx_1] && !reset));
        assert (!(alloc_valid_2 && entry_valid[alloc_idx_2] && !reset));
        @(posedge clk);
        #1;
        alloc_valid_1 = 1'b0;
        alloc_valid_2 = 1'b0;
        flush_mask    = '0;
    endtask

    task automatic alloc1(input int idx, input logic port);
        alloc_valid_1 = 1'b1; alloc_idx_1 = S'(idx); alloc_port_1 = port;
    endtask

    task automatic alloc2(input int idx, input logic port);
        alloc_valid_2 = 1'b1; alloc_idx_2 = S'(idx); alloc_port_2 = port;
    endtask

    initial begin
        reset = 1'b1;
        alloc_valid_1 = 0; alloc_idx_1 = '0; alloc_port_1 = 0;
        alloc_valid_2 = 0; alloc_idx_2 = '0; alloc_port_2 = 0;
        request = '0; flush_mask = '0; port_ready_1 = 1; port_ready_2 = 1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_free", 32'(free_count), 16);
        check("rst_alloc", 32'(allocatable), 1);
        check("rst_gv1", 32'(grant_valid_1), 0);
        check("rst_gv2", 32'(grant_valid_2), 0);
        check("rst_gi1", 32'(grant_idx_1), 0);
        check("rst_ev", 32'(entry_valid), 0);

        // e3 then e7 on port 1: older e3 issues first
        alloc1(3, 0); tick();
        check("a3_ev", 32'(entry_valid), 32'h0008);
        check("a3_free", 32'(free_count), 15);
        alloc1(7, 0); tick();
        check("a7_ev", 32'(entry_valid), 32'h0088);
        request = 16'h0088; tick();
        check("o1_gv1", 32'(grant_valid_1), 1);
        check("o1_gi1", 32'(grant_idx_1), 3);
        check("o1_gv2", 32'(grant_valid_2), 0);
        check("o1_ev", 32'(entry_valid), 32'h0080);
        tick();
        check("o2_gv1", 32'(grant_valid_1), 1);
        check("o2_gi1", 32'(grant_idx_1), 7);
        check("o2_free", 32'(free_count), 16);
        request = '0;

        // dual alloc e5 (older) and e2 on port 2: age beats index
        alloc1(5, 1); alloc2(2, 1); tick();
        check("d_ev", 32'(entry_valid), 32'h0024);
        check("d_free", 32'(free_count), 14);
        request = 16'h0024; tick();
        check("d1_gv2", 32'(grant_valid_2), 1);
        check("d1_gi2", 32'(grant_idx_2), 5);
        check("d1_gv1", 32'(grant_valid_1), 0);
        check("d1_gi1_hold", 32'(grant_idx_1), 7);
        tick();
        check("d2_gi2", 32'(grant_idx_2), 2);
        check("d2_ev", 32'(entry_valid), 0);
        request = '0;

        // port 2 back-pressure keeps e9 queued
        alloc1(1, 0); alloc2(9, 1); tick();
        check("bp_ev", 32'(entry_valid), 32'h0202);
        request = 16'h0202; port_ready_2 = 0; tick();
        check("bp_gv1", 32'(grant_valid_1), 1);
        check("bp_gi1", 32'(grant_idx_1), 1);
        check("bp_gv2", 32'(grant_valid_2), 0);
        check("bp_gi2_hold", 32'(grant_idx_2), 2);
        check("bp_ev2", 32'(entry_valid), 32'h0200);
        port_ready_2 = 1; tick();
        check("bp_rel_gv2", 32'(grant_valid_2), 1);
        check("bp_rel_gi2", 32'(grant_idx_2), 9);
        check("bp_rel_gv1", 32'(grant_valid_1), 0);
        request = '0;

        // flush beats grant
        alloc1(4, 0); tick();
        check("f_free0", 32'(free_count), 15);
        request = 16'h0010; flush_mask = 16'h0010; tick();
        check("f_gv1", 32'(grant_valid_1), 0);
        check("f_ev", 32'(entry_valid), 0);
        check("f_free1", 32'(free_count), 16);
        request = '0;

        // flush of a just-allocated entry is ignored
        alloc1(6, 0); flush_mask = 16'h0040; tick();
        check("fa_ev", 32'(entry_valid), 32'h0040);
        flush_mask = 16'h0040; tick();
        check("fa_ev2", 32'(entry_valid), 0);

        // fill to the allocatable boundary
        for (int p = 0; p < 7; p++) begin
            alloc1(2*p, 0); alloc2(2*p+1, 0); tick();
        end
        check("fill14_free", 32'(free_count), 2);
        check("fill14_alloc", 32'(allocatable), 1);
        alloc1(14, 0); tick();
        check("fill15_ev", 32'(entry_valid), 32'h7FFF);
        check("fill15_free", 32'(free_count), 1);
        check("fill15_alloc", 32'(allocatable), 0);
        request = 16'h7FFF; tick();
        check("fg_gi1", 32'(grant_idx_1), 0);
        check("fg_free", 32'(free_count), 2);
        check("fg_alloc", 32'(allocatable), 1);
        tick();
        check("fg2_gi1", 32'(grant_idx_1), 1);
        request = '0; flush_mask = 16'hFFFF; tick();
        check("fl_all_ev", 32'(entry_valid), 0);
        check("fl_all_free", 32'(free_count), 16);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
